// File: rtl/rand_arbiter.sv
// Round-robin arbiter that grants one requester at a time a pseudo-random roll.
// A 4-bit LFSR advances only while rolling; each completed roll is returned on
// o_data and recorded in a small per-requester history that can be read back.
module rand_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned ROLL_CYC = 4,
  parameter logic [3:0]  SEED     = 4'd3
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [NREQ-1:0] i_req,
  output logic [NREQ-1:0] o_gnt,
  output logic            o_valid,
  output logic [3:0]      o_data,
  output logic            o_busy,
  input  logic            i_prev_rd,
  input  logic [1:0]      i_prev_sel,
  output logic [3:0]      o_prev_data,
  output logic            o_prev_valid
);

  typedef enum logic [1:0] {StIdle, StRoll, StDone} state_e;

  state_e          state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [1:0]      winner_q, winner_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [3:0]      lfsr_q, lfsr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [3:0]      data_q, data_d;
  logic [3:0]      hist_q [4];
  logic            hist_we;
  logic [3:0]      prev_data_q;
  logic            prev_valid_q;

  logic            rr_found;
  logic [1:0]      rr_win;
  logic [1:0]      rr_idx;

  // All-zero state would lock up, so it is forced back into the sequence.
  function automatic logic [3:0] lfsr_step(input logic [3:0] cur);
    if (cur == 4'd0) begin
      return 4'd12;
    end
    return {cur[0] ^ cur[3], cur[3:1]};
  endfunction

  // Round-robin search starting at ptr and wrapping modulo 4.
  always_comb begin
    rr_found = 1'b0;
    rr_win   = ptr_q;
    rr_idx   = '0;
    for (int i = 0; i < 4; i++) begin
      rr_idx = ptr_q + 2'(i);
      if (!rr_found && i_req[rr_idx]) begin
        rr_found = 1'b1;
        rr_win   = rr_idx;
      end
    end
  end

  // FSM next state, grant, counter, LFSR and result capture.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    winner_d = winner_q;
    cnt_d    = cnt_q;
    lfsr_d   = lfsr_q;
    gnt_d    = gnt_q;
    data_d   = data_q;
    hist_we  = 1'b0;
    case (state_q)
      StIdle: begin
        if (rr_found) begin
          state_d  = StRoll;
          winner_d = rr_win;
          gnt_d    = NREQ'(1) << rr_win;
          cnt_d    = 4'(ROLL_CYC - 1);
        end
      end
      StRoll: begin
        // The LFSR keeps stepping on an abort cycle; it is never rewound.
        lfsr_d = lfsr_step(lfsr_q);
        if (!i_req[winner_q]) begin
          state_d = StIdle;
          gnt_d   = '0;
          ptr_d   = winner_q + 2'd1;
        end else if (cnt_q == 4'd0) begin
          state_d = StDone;
          data_d  = lfsr_step(lfsr_q);
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        hist_we = 1'b1;
        state_d = StIdle;
        gnt_d   = '0;
        ptr_d   = winner_q + 2'd1;
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      ptr_q    <= 2'd0;
      winner_q <= 2'd0;
      cnt_q    <= 4'd0;
      lfsr_q   <= SEED;
      gnt_q    <= '0;
      data_q   <= 4'd0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      winner_q <= winner_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
      gnt_q    <= gnt_d;
      data_q   <= data_d;
    end
  end

  // History storage and read port; a same-cycle read sees the old entry.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 4; i++) begin
        hist_q[i] <= 4'd0;
      end
      prev_data_q  <= 4'd0;
      prev_valid_q <= 1'b0;
    end else begin
      if (hist_we) begin
        hist_q[winner_q] <= lfsr_q;
      end
      if (i_prev_rd) begin
        prev_data_q <= hist_q[i_prev_sel];
      end
      prev_valid_q <= i_prev_rd;
    end
  end

  // Output drive.
  always_comb begin
    o_gnt        = gnt_q;
    o_valid      = (state_q == StDone);
    o_data       = data_q;
    o_busy       = (state_q != StIdle);
    o_prev_data  = prev_data_q;
    o_prev_valid = prev_valid_q;
  end

endmodule

// File: tb/tb_rand_arbiter.sv
// Directed bench for rand_arbiter: default build plus a SEED=0, ROLL_CYC=1 build.
module tb_rand_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req, req0;
  logic       prev_rd, prev_rd0;
  logic [1:0] prev_sel, prev_sel0;
  logic [3:0] gnt, gnt0;
  logic       valid, valid0;
  logic [3:0] data, data0;
  logic       busy, busy0;
  logic [3:0] prev_data, prev_data0;
  logic       prev_valid, prev_valid0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rand_arbiter dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req        (req),
    .o_gnt        (gnt),
    .o_valid      (valid),
    .o_data       (data),
    .o_busy       (busy),
    .i_prev_rd    (prev_rd),
    .i_prev_sel   (prev_sel),
    .o_prev_data  (prev_data),
    .o_prev_valid (prev_valid)
  );

  rand_arbiter #(
    .NREQ     (4),
    .ROLL_CYC (1),
    .SEED     (4'd0)
  ) dut0 (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req        (req0),
    .o_gnt        (gnt0),
    .o_valid      (valid0),
    .o_data       (data0),
    .o_busy       (busy0),
    .i_prev_rd    (prev_rd0),
    .i_prev_sel   (prev_sel0),
    .o_prev_data  (prev_data0),
    .o_prev_valid (prev_valid0)
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] one;
    logic [3:0] exp_g;
    int         slot;
    int         ph;
    one       = 4'b0001;
    rst_n     = 1'b0;
    req       = 4'd0;
    prev_rd   = 1'b0;
    prev_sel  = 2'd0;
    req0      = 4'd0;
    prev_rd0  = 1'b0;
    prev_sel0 = 2'd0;
    tick();
    tick();

    // Reset state
    check("rst_gnt", gnt, 4'd0);
    check("rst_valid", {3'd0, valid}, 4'd0);
    check("rst_data", data, 4'd0);
    check("rst_busy", {3'd0, busy}, 4'd0);
    check("rst_prev_data", prev_data, 4'd0);
    check("rst_prev_valid", {3'd0, prev_valid}, 4'd0);

    // First roll for requester 0: LFSR 3->9->4->2->1
    rst_n = 1'b1;
    req   = 4'b0001;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("roll1_gnt", gnt, 4'b0001);
      check("roll1_valid", {3'd0, valid}, {3'd0, k == 5});
    end
    check("roll1_data", data, 4'h1);
    check("roll1_busy", {3'd0, busy}, 4'd1);
    // Read in the DONE cycle returns the pre-write value
    prev_rd  = 1'b1;
    prev_sel = 2'd0;
    tick();
    check("idle_gnt", gnt, 4'd0);
    check("idle_valid", {3'd0, valid}, 4'd0);
    check("idle_busy", {3'd0, busy}, 4'd0);
    check("rd_same_cycle_valid", {3'd0, prev_valid}, 4'd1);
    check("rd_same_cycle_data", prev_data, 4'h0);
    check("data_hold", data, 4'h1);
    tick();
    check("rd_after_write", prev_data, 4'h1);
    check("roll2_gnt_start", gnt, 4'b0001);
    prev_rd = 1'b0;

    // Second roll continues the LFSR: 1->8->C->E->F
    for (int k = 2; k <= 5; k++) begin
      tick();
      check("roll2_valid", {3'd0, valid}, {3'd0, k == 5});
      if (k == 2) check("prev_valid_drop", {3'd0, prev_valid}, 4'd0);
    end
    check("roll2_data", data, 4'hF);

    // Abort: requester 0 drops in its 2nd ROLL cycle, requester 1 takes over
    tick();
    check("pre_abort_idle", gnt, 4'd0);
    tick();
    check("abort_roll1_gnt", gnt, 4'b0001);
    tick();
    req = 4'b0010;
    tick();
    check("abort_gnt", gnt, 4'd0);
    check("abort_valid", {3'd0, valid}, 4'd0);
    check("abort_busy", {3'd0, busy}, 4'd0);
    tick();
    check("after_abort_gnt", gnt, 4'b0010);
    prev_rd  = 1'b1;
    prev_sel = 2'd0;
    req      = 4'b0011;
    tick();
    check("abort_no_hist_write", prev_data, 4'hF);
    check("ignore_other_req", gnt, 4'b0010);
    prev_rd = 1'b0;

    // Reset asserted mid-ROLL
    rst_n = 1'b0;
    #1;
    check("midroll_rst_gnt", gnt, 4'd0);
    check("midroll_rst_valid", {3'd0, valid}, 4'd0);
    check("midroll_rst_busy", {3'd0, busy}, 4'd0);
    req = 4'b1111;
    tick();
    tick();

    // All requesters held: rotating grants with one idle cycle between
    rst_n    = 1'b1;
    prev_rd  = 1'b1;
    prev_sel = 2'd0;
    for (int c = 0; c < 26; c++) begin
      tick();
      slot  = c / 6;
      ph    = c % 6;
      exp_g = (ph < 5) ? (one << (slot % 4)) : 4'd0;
      check("rr_gnt", gnt, exp_g);
      check("rr_valid", {3'd0, valid}, {3'd0, ph == 4});
      if (c == 0) begin
        check("hist_reset_cleared", prev_data, 4'h0);
        prev_rd = 1'b0;
      end
      if (c == 4) check("rr_data_first", data, 4'h1);
      if (c == 10) check("rr_data_second", data, 4'hF);
    end
    req = 4'd0;
    tick();

    // SEED=0, ROLL_CYC=1 build: 0 -> C
    req0 = 4'b0001;
    tick();
    check("seed0_gnt", gnt0, 4'b0001);
    check("seed0_roll_valid", {3'd0, valid0}, 4'd0);
    tick();
    check("seed0_valid", {3'd0, valid0}, 4'd1);
    check("seed0_data", data0, 4'hC);
    req0 = 4'd0;
    tick();
    check("seed0_gnt_clear", gnt0, 4'd0);
    check("seed0_valid_clear", {3'd0, valid0}, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
